// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, frame type and hex-to-segment decode for the scan driver.
package seg7_pkg;
  localparam int NUM_DIG = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] CS_NONE = 8'hFF;
  typedef struct packed {
    logic [NUM_DIG-1:0][3:0] d;
    logic [7:0] dot;
    logic [7:0] en;
  } frame_t;
  // Active-low a..g patterns; dp is added separately by the caller.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] seg7_hex(input logic [3:0] h);
    return SEG_LUT[h];
  endfunction
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: frame load bus and display pins of the seven-segment scan driver.
interface seg7_scan_driver_if;
  logic load;
  logic [31:0] digits;
  logic [7:0] dots;
  logic [7:0] en;
  logic load_ack;
  logic frame_start;
  logic [7:0] cs;
  logic [7:0] o_dig_sel;
  modport master (output load, digits, dots, en, input load_ack, frame_start, cs, o_dig_sel);
  modport slave (input load, digits, dots, en, output load_ack, frame_start, cs, o_dig_sel);
endinterface

// File: rtl/seg7_frame_buffer.sv
// seg7_frame_buffer: shadow/active double buffer committed only at the frame boundary.
module seg7_frame_buffer
  import seg7_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_load,
  input  logic   i_commit,
  input  frame_t i_frame,
  output frame_t o_act,
  output logic   o_ack
);
  frame_t r_shadow, r_active;
  logic r_pend, r_ack;
  // A load in the commit cycle bypasses the shadow so it is not delayed a whole frame.
  assign o_act = !i_commit ? r_active : i_load ? i_frame : r_pend ? r_shadow : r_active;
  assign o_ack = r_ack;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pend <= 1'b0;
      r_ack <= 1'b0;
    end else begin
      if (i_load) r_shadow <= i_frame;
      r_active <= o_act;
      r_pend <= !i_commit && (i_load || r_pend);
      r_ack <= i_commit && (i_load || r_pend);
    end
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 8-digit seven-segment driver with per-slot blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int F_CLK = 50000000,
  parameter int F_SCAN = 1000,
  parameter int BLANK_CYCLES = 500
) (
  input logic clk,
  input logic rst,
  seg7_scan_driver_if.slave bus
);
  localparam int SLOT = F_CLK / F_SCAN;
  localparam int PW = $clog2(SLOT);
  logic [PW-1:0] r_pre, w_pre_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic w_tick, w_wrap, w_blank, w_ack, r_fs;
  logic [6:0] w_seg;
  logic [7:0] w_lit, r_cs, r_seg;
  frame_t w_in, w_act;
  assign w_in = {bus.digits, bus.dots, bus.en};
  assign w_tick = r_pre == PW'(SLOT - 1);
  assign w_wrap = w_tick && r_ptr == 3'(NUM_DIG - 1);
  assign w_pre_nxt = w_tick ? '0 : r_pre + PW'(1);
  assign w_ptr_nxt = r_ptr + 3'(w_tick);
  seg7_frame_buffer u_fb (
    .clk(clk),
    .rst(rst),
    .i_load(bus.load),
    .i_commit(w_wrap),
    .i_frame(w_in),
    .o_act(w_act),
    .o_ack(w_ack)
  );
  // Outputs are decoded from next-state values so they line up with the slot they describe.
  assign w_blank = w_pre_nxt < PW'(BLANK_CYCLES);
  assign w_seg = seg7_hex(w_act.d[w_ptr_nxt]);
  assign w_lit = w_act.en[w_ptr_nxt] ? {~w_act.dot[w_ptr_nxt], w_seg} : SEG_BLANK;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_ptr <= '0;
      r_fs <= 1'b0;
      r_cs <= CS_NONE;
      r_seg <= SEG_BLANK;
    end else begin
      r_pre <= w_pre_nxt;
      r_ptr <= w_ptr_nxt;
      r_fs <= w_wrap;
      r_cs <= w_blank ? CS_NONE : ~(8'b1 << w_ptr_nxt);
      r_seg <= w_blank ? SEG_BLANK : w_lit;
    end
  end
  assign bus.cs = r_cs;
  assign bus.o_dig_sel = r_seg;
  assign bus.frame_start = r_fs;
  assign bus.load_ack = w_ack;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed vector bench, SLOT=10 and two blank cycles per slot.
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  seg7_scan_driver_if bus ();
  seg7_scan_driver #(.F_CLK(100), .F_SCAN(10), .BLANK_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;

  typedef struct {
    int k;
    logic ld;
    logic [31:0] dg;
    logic [7:0] dt;
    logic [7:0] e;
    logic chk;
    logic [7:0] cs;
    logic [7:0] seg;
    logic ack;
    logic fs;
  } vec_t;

  vec_t tv[$];
  int total = 0, bad = 0, k = 0, acks = 0, idx = 0;

  function automatic vec_t L(int kk, logic [31:0] dg, logic [7:0] dt, logic [7:0] e);
    vec_t v;
    v.k = kk; v.ld = 1'b1; v.dg = dg; v.dt = dt; v.e = e;
    v.chk = 1'b0; v.cs = 8'h00; v.seg = 8'h00; v.ack = 1'b0; v.fs = 1'b0;
    return v;
  endfunction

  function automatic vec_t C(int kk, logic [7:0] cs, logic [7:0] seg, logic ack, logic fs);
    vec_t v;
    v.k = kk; v.ld = 1'b0; v.dg = '0; v.dt = '0; v.e = '0;
    v.chk = 1'b1; v.cs = cs; v.seg = seg; v.ack = ack; v.fs = fs;
    return v;
  endfunction

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s k=%0d got=%h exp=%h", n, k, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    bus.load = 1'b0;
    if (bus.load_ack) acks++;
  endtask

  task automatic run_to(input int t);
    while (k < t) step();
  endtask

  task automatic run_rows(input int hi);
    while (idx < tv.size() && tv[idx].k <= hi) begin
      run_to(tv[idx].k);
      if (tv[idx].chk) begin
        chk("cs", bus.cs, tv[idx].cs);
        chk("seg", bus.o_dig_sel, tv[idx].seg);
        chk("ack", 8'(bus.load_ack), 8'(tv[idx].ack));
        chk("fs", 8'(bus.frame_start), 8'(tv[idx].fs));
      end
      if (tv[idx].ld) begin
        bus.digits = tv[idx].dg;
        bus.dots = tv[idx].dt;
        bus.en = tv[idx].e;
        bus.load = 1'b1;
      end
      idx++;
    end
  endtask

  // Empty active buffer: cs still scans but no segment is ever lit.
  task automatic idle_frame(input int upto);
    logic [7:0] exp_cs;
    while (k <= upto) begin
      exp_cs = (k % 10 < 2) ? 8'hFF : ~(8'b1 << ((k / 10) % 8));
      chk("idle_cs", bus.cs, exp_cs);
      chk("idle_seg", bus.o_dig_sel, 8'hFF);
      chk("idle_ack", 8'(bus.load_ack), 8'h00);
      chk("idle_fs", 8'(bus.frame_start), 8'(k == 80));
      step();
    end
  endtask

  initial begin
    bus.load = 1'b0;
    bus.digits = '0;
    bus.dots = '0;
    bus.en = '0;
    tv.push_back(L(85, 32'h76543210, 8'h01, 8'hFF));
    tv.push_back(C(159, 8'h7F, 8'hFF, 1'b0, 1'b0));
    tv.push_back(C(160, 8'hFF, 8'hFF, 1'b1, 1'b1));
    tv.push_back(C(161, 8'hFF, 8'hFF, 1'b0, 1'b0));
    tv.push_back(C(162, 8'hFE, 8'h40, 1'b0, 1'b0));
    tv.push_back(C(169, 8'hFE, 8'h40, 1'b0, 1'b0));
    tv.push_back(C(170, 8'hFF, 8'hFF, 1'b0, 1'b0));
    tv.push_back(C(172, 8'hFD, 8'hF9, 1'b0, 1'b0));
    tv.push_back(C(182, 8'hFB, 8'hA4, 1'b0, 1'b0));
    tv.push_back(C(192, 8'hF7, 8'hB0, 1'b0, 1'b0));
    tv.push_back(C(232, 8'h7F, 8'hF8, 1'b0, 1'b0));
    tv.push_back(C(239, 8'h7F, 8'hF8, 1'b0, 1'b0));
    tv.push_back(C(480, 8'hFF, 8'hFF, 1'b0, 1'b1));
    tv.push_back(L(512, 32'h88888888, 8'h00, 8'hFF));
    tv.push_back(C(515, 8'hF7, 8'hB0, 1'b0, 1'b0));
    tv.push_back(L(532, 32'hFFFFFFFF, 8'h00, 8'hFF));
    tv.push_back(C(535, 8'hDF, 8'h92, 1'b0, 1'b0));
    tv.push_back(C(545, 8'hBF, 8'h82, 1'b0, 1'b0));
    tv.push_back(C(555, 8'h7F, 8'hF8, 1'b0, 1'b0));
    tv.push_back(C(560, 8'hFF, 8'hFF, 1'b1, 1'b1));
    tv.push_back(C(562, 8'hFE, 8'h8E, 1'b0, 1'b0));
    tv.push_back(C(572, 8'hFD, 8'h8E, 1'b0, 1'b0));
    tv.push_back(C(632, 8'h7F, 8'h8E, 1'b0, 1'b0));
    tv.push_back(C(639, 8'h7F, 8'h8E, 1'b0, 1'b0));
    tv.push_back(L(639, 32'hAAAAAAAA, 8'h00, 8'hFF));
    tv.push_back(C(640, 8'hFF, 8'hFF, 1'b1, 1'b1));
    tv.push_back(C(642, 8'hFE, 8'h88, 1'b0, 1'b0));
    tv.push_back(C(712, 8'h7F, 8'h88, 1'b0, 1'b0));
    tv.push_back(C(720, 8'hFF, 8'hFF, 1'b0, 1'b1));
    tv.push_back(C(722, 8'hFE, 8'h88, 1'b0, 1'b0));
    tv.push_back(L(730, 32'h76543210, 8'h00, 8'h04));
    tv.push_back(C(800, 8'hFF, 8'hFF, 1'b1, 1'b1));
    tv.push_back(C(805, 8'hFE, 8'hFF, 1'b0, 1'b0));
    tv.push_back(C(815, 8'hFD, 8'hFF, 1'b0, 1'b0));
    tv.push_back(C(825, 8'hFB, 8'hA4, 1'b0, 1'b0));
    tv.push_back(C(835, 8'hF7, 8'hFF, 1'b0, 1'b0));
    tv.push_back(L(900, 32'h11111111, 8'h00, 8'hFF));
    tv.push_back(C(905, 8'hFB, 8'hA4, 1'b0, 1'b0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", bus.cs, 8'hFF);
    chk("rst_seg", bus.o_dig_sel, 8'hFF);
    chk("rst_ack", 8'(bus.load_ack), 8'h00);
    chk("rst_fs", 8'(bus.frame_start), 8'h00);
    rst = 1'b0;
    k = 0;
    idle_frame(80);

    run_rows(239);
    run_to(240);
    while (k < 480) begin
      if (k % 10 < 2) begin
        chk("blank_cs", bus.cs, 8'hFF);
        chk("blank_seg", bus.o_dig_sel, 8'hFF);
      end else begin
        chk("one_cs", 8'($countones(~bus.cs)), 8'd1);
      end
      step();
    end

    acks = 0;
    run_rows(632);
    chk("dbuf_acks", 8'(acks), 8'd1);

    run_rows(905);
    rst = 1'b1;
    #1;
    chk("async_cs", bus.cs, 8'hFF);
    chk("async_seg", bus.o_dig_sel, 8'hFF);
    chk("async_ack", 8'(bus.load_ack), 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    idle_frame(85);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
